// File: rtl/key_matrix_emu.sv
// 4x4 keypad responder: turns press commands into column levels for a row scanner.
// Optional contact bounce emulation when KEY_BOUNCE_EN is defined.
module key_matrix_emu #(
  parameter int HOLD_W     = 16,
  parameter int GAP_CYC    = 32,
  parameter int BOUNCE_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        kr_sel,
  output logic [3:0]        kc_sel,
  input  logic              cmd_valid,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              cmd_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        press_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [15:0] GAP_INIT = 16'(GAP_CYC);

  state_t            state;
  logic [3:0]        key;
  logic [HOLD_W-1:0] hold_cnt;
  logic [15:0]       gap_cnt;
  logic              contact;
  logic              accept;
  logic              last_press;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = cmd_ready && cmd_valid;
  assign last_press = (state == PRESS) && (hold_cnt == HOLD_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key       <= '0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      done      <= 1'b0;
      press_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            key      <= cmd_key;
            hold_cnt <= (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
            state    <= PRESS;
          end
        end
        PRESS: begin
          if (hold_cnt == HOLD_W'(1)) begin
            state   <= GAP;
            gap_cnt <= GAP_INIT;
            done    <= (GAP_INIT == 16'd1);
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        GAP: begin
          // done is raised while the final gap cycle is showing
          if (gap_cnt == 16'd1) begin
            state     <= IDLE;
            press_cnt <= press_cnt + 8'd1;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
            done    <= (gap_cnt == 16'd2);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_BOUNCE_EN
  logic [2:0]  lfsr;
  logic [15:0] bcnt;
  logic        win;

  assign win = (state != IDLE) && (bcnt < 16'(BOUNCE_CYC));

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      lfsr <= 3'b101;
      bcnt <= '0;
    end else begin
      if (win)
        lfsr <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
      if (last_press)
        bcnt <= '0;
      else if (win)
        bcnt <= bcnt + 16'd1;
    end
  end

  always_comb begin
    contact = (state == PRESS);
    if (last_press)
      contact = 1'b1;
    else if (win)
      contact = lfsr[0];
  end
`else
  assign contact = (state == PRESS);
`endif

  always_comb begin
    kc_sel = 4'b1111;
    if (contact && !kr_sel[key[3:2]])
      kc_sel = ~(4'b0001 << key[1:0]);
  end

endmodule

// File: tb/tb_key_matrix_emu.sv
// Randomized bench for key_matrix_emu against a timeline model of each press.
module tb_key_matrix_emu;

  localparam int G = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  kr_sel;
  logic [3:0]  kc_sel;
  logic        cmd_valid;
  logic [3:0]  cmd_key;
  logic [15:0] cmd_hold;
  logic        cmd_ready;
  logic        busy;
  logic        done;
  logic [7:0]  press_cnt;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  bit act = 0;
  int acc = 0;
  int mh = 0;
  int mk = 0;
  int mcnt = 0;
  bit took = 0;

  always #5 clk = ~clk;

  key_matrix_emu #(
    .HOLD_W(16),
    .GAP_CYC(G),
    .BOUNCE_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kr_sel(kr_sel),
    .kc_sel(kc_sel),
    .cmd_valid(cmd_valid),
    .cmd_key(cmd_key),
    .cmd_hold(cmd_hold),
    .cmd_ready(cmd_ready),
    .busy(busy),
    .done(done),
    .press_cnt(press_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [3:0] rot(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (i % 4));
  endfunction

  task automatic step(input bit v, input logic [3:0] k,
                      input int h, input logic [3:0] kr,
                      input bit r);
    bit closed;
    int ekc;
    cmd_valid = v;
    cmd_key   = k;
    cmd_hold  = h[15:0];
    kr_sel    = kr;
    rst       = r;
    @(negedge clk);
    if (act && cyc > acc + mh + G) begin
      act  = 0;
      mcnt = (mcnt + 1) % 256;
    end
    closed = act && cyc >= acc + 1 && cyc <= acc + mh;
    ekc = 15;
    if (closed && kr[mk / 4] == 1'b0)
      ekc = (~(1 << (mk % 4))) & 15;
    chk("kc_sel", int'(kc_sel), ekc);
    chk("cmd_ready", int'(cmd_ready), int'(!act));
    chk("busy", int'(busy), int'(act));
    chk("done", int'(done), int'(act && cyc == acc + mh + G));
    chk("press_cnt", int'(press_cnt), mcnt);
    took = 0;
    if (r) begin
      act  = 0;
      mcnt = 0;
    end else if (!act && v) begin
      act  = 1;
      acc  = cyc;
      mh   = (h == 0) ? 1 : h;
      mk   = int'(k);
      took = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [3:0] keys [4];
    keys[0] = 4'h0;
    keys[1] = 4'h5;
    keys[2] = 4'hA;
    keys[3] = 4'hF;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_key = '0;
    cmd_hold = '0;
    kr_sel = 4'b1111;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++)
      step(0, 4'h0, 0, rot(i), 0);

    step(1, 4'h6, 10, 4'b1101, 0);
    repeat (10 + G + 3)
      step(0, 4'h0, 0, 4'b1101, 0);

    step(1, 4'hF, 100, 4'b1110, 0);
    for (int i = 0; i < 100 + G + 3; i++)
      step(0, 4'h0, 0, rot(i), 0);

    for (int j = 0; j < 4; j++) begin
      int n;
      int h;
      n = 0;
      h = int'($urandom_range(1, 8));
      do begin
        step(1, keys[j], h, 4'($urandom), 0);
        n++;
      end while (!took && n < 200);
      chk("accept_key", int'(took), 1);
    end
    repeat (12 + G)
      step(0, 4'h0, 0, 4'($urandom), 0);
    chk("four_done", int'(press_cnt), (mcnt == 0) ? -1 : mcnt);

    step(1, 4'h3, 20, 4'b1110, 0);
    repeat (5)
      step(0, 4'h0, 0, 4'b1110, 0);
    step(0, 4'h0, 0, 4'b1110, 1);
    repeat (4)
      step(0, 4'h0, 0, 4'b1110, 0);

    step(1, 4'h9, 0, 4'b1011, 0);
    repeat (G + 3)
      step(0, 4'h0, 0, 4'b1011, 0);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) == 0, 4'($urandom),
           int'($urandom_range(0, 15)), 4'($urandom),
           $urandom_range(0, 299) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_matrix_emu.md
Name: key_matrix_emu

Overview:
- Behavioural-synthesizable 4x4 keypad matrix emulator: the responder end of the row-scan/column-sense keypad interface.
- Watches the row-select strobes driven by the scanner (kr_sel) and returns column levels (kc_sel) as a physical keypad would for one commanded key.
- Accepts press commands over a valid/ready handshake and sequences press, hold, release and inter-key gap.
- Used in FPGA self-test builds and benches to drive the scanner/keyboard/key-buffer chain without hardware.

Parameters:
- HOLD_W, 16, width of cmd_hold and the hold counter.
- GAP_CYC, 32, released cycles forced after each key before done/ready (minimum 1).
- BOUNCE_CYC, 8, bounce window length in cycles (used only with KEY_BOUNCE_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- kr_sel  input  4  row select from scanner, active-low, one row low at a time.
- kc_sel  output  4  column sense to decoder, active-low, 4'b1111 = no key.
- cmd_valid  input  1  press command valid.
- cmd_key  input  4  key index: row = cmd_key[3:2], col = cmd_key[1:0].
- cmd_hold  input  HOLD_W  hold length in clk cycles; 0 treated as 1.
- cmd_ready  output  1  high in IDLE only.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at end of GAP.
- press_cnt  output  8  completed commands, wraps 255->0.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, kc_sel=4'b1111, cmd_ready=1, busy=0, done=0, press_cnt=0, latched key=0. Reset mid-operation aborts immediately; no done pulse; the key releases on the next cycle.
- The state register is the only sequential driver. kc_sel is decoded combinationally from the registered contact state and the live kr_sel (zero-latency column response):
  - contact closed and kr_sel[row]==0 -> kc_sel = ~(4'b0001 << col);
  - otherwise kc_sel = 4'b1111.
- A kr_sel with several bits low is legal. kc_sel still reflects only the latched key's row bit.
- Handshake: a command is accepted on a cycle where cmd_valid && cmd_ready. Key and hold are latched and the FSM goes to PRESS. cmd_valid without ready is ignored; commands are not queued.
- IDLE:
  - contact open;
  - cmd_ready=1;
  - on accept: hold counter <= max(cmd_hold,1), go to PRESS.
- PRESS:
  - contact closed;
  - hold counter decrements each cycle;
  - when counter==1, go to GAP with gap counter <= GAP_CYC.
  - Contact is closed for exactly max(cmd_hold,1) cycles, beginning the cycle after accept.
- GAP:
  - contact open;
  - gap counter decrements;
  - when counter==1: done=1 for one cycle, press_cnt += 1, go to IDLE.
  - cmd_ready returns high the cycle after done, so back-to-back keys are separated by GAP_CYC + 1 open cycles minimum.
- cmd_hold = all ones is legal; the counter must not overflow.
- Counters are HOLD_W bits and 16 bits (gap) respectively; both are unsigned.

Optional Feature:
- Macro: KEY_BOUNCE_EN.
- Defined:
  - the first BOUNCE_CYC cycles of PRESS and the first BOUNCE_CYC cycles of GAP emulate contact bounce;
  - the contact is driven by a 3-bit LFSR, seed 3'b101 at reset and at each accept, polynomial x^3+x^2+1, advanced every cycle in the window; bit0 = contact closed;
  - outside the window, behaviour is normal;
  - if hold < BOUNCE_CYC, the whole PRESS is bounced, and the final PRESS cycle forces contact closed;
  - total state timing is unchanged.
- Undefined: clean edges as above; no LFSR logic is synthesized.

Test Plan:
- Reset then idle, kr_sel cycling 1110/1101/1011/0111 -> kc_sel=1111 always, cmd_ready=1, press_cnt=0.
- Accept key 4'h6, hold=10 with kr_sel=1101 held -> kc_sel=1011 for exactly 10 cycles starting the cycle after accept. Then 1111; done pulses GAP_CYC cycles later; press_cnt=1.
- Key 4'hF, hold=100, kr_sel rotating each cycle -> kc_sel=0111 only on cycles with kr_sel=0111, else 1111.
- cmd_valid held high with keys 0,5,A,F -> four accepts spaced hold+GAP_CYC+1 cycles; press_cnt=4; extra cmd_valid pulses while busy are dropped.
- Assert rst mid-PRESS of key 4'h3 -> kc_sel=1111 next cycle, no done, press_cnt=0, cmd_ready=1.
- hold=0 -> contact closed exactly 1 cycle. Full chain with stud21_1_top scanner -> key buffer records scan_code 4'h6.
